// File: rtl/wg_pkg.sv
// Package shared by the 3x3 window generator.
//   wg_state_t : frame-level state (idle / streaming a frame)
//   WG_K       : window edge length
//   WG_NCELL   : cells per window
//   cell_idx   : cell number of window position (r,c); r0 = top row, c0 = left column
package wg_pkg;

    typedef enum logic {
        WG_IDLE = 1'b0,
        WG_RUN  = 1'b1
    } wg_state_t;

    localparam int WG_K     = 3;
    localparam int WG_NCELL = 9;

    function automatic int cell_idx(input int r, input int c);
        return r * WG_K + c;
    endfunction

endpackage

// File: rtl/wg_line_buffer.sv
// One image-row line buffer.
// It is a DEPTH x WIDTH RAM with a single address.
// The read is combinational and returns the contents stored before any write in this cycle.
// A write to the same address is committed at the clock edge.
// Reading and rewriting a column in one cycle therefore yields the old pixel.
// Ports:
//   clk     in   clock, rising edge
//   we      in   write enable
//   addr    in   column address
//   wr_data in   pixel to store
//   rd_data out  pixel currently stored at addr (old data)
// The contents are never cleared.
module wg_line_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator.
// It accepts raster-order pixels and keeps the previous two rows in line buffers (lb0 = row-1, lb1 = row-2).
// It emits every complete 3x3 window, with no padding, one cycle after the pixel that completes it.
//
// Optional feature:
//   WG_STRIDE2_EN adds cfg_stride2. The value is latched at start.
//   When set, only windows whose top-left corner sits on even (row, col) are emitted.
//
// Ports:
//   clk, reset   clock (rising edge) and synchronous active-low reset
//   start        begin a frame; honoured only in idle
//   cfg_width    image width W, legal range 3..MAX_W
//   cfg_height   image height H, legal minimum 3
//   cfg_stride2  (WG_STRIDE2_EN only) emit on stride 2
//   pix_in       input pixel
//   pix_valid    input pixel is valid
//   pix_ready    the block can accept a pixel
//   hold         downstream stall input
//   win_out      packed window; cell r*3+c at [cell_bit*k +: cell_bit]
//   win_en       win_out valid pulse
//   frame_done   pulse after the last pixel of the frame
//   cfg_err      pulse when start is rejected for an illegal configuration
//   fsm_state    current frame state (observation only)
//
// Handshake:
//   A pixel transfers on a rising edge when pix_valid && pix_ready.
//   pix_ready is high only while a frame is running and hold is low.
//   pix_valid may be driven independently of pix_ready.
//   Without a transfer, all pipeline state holds and win_en stays low.
module window_gen_3x3
    import wg_pkg::*;
#(
    parameter int cell_bit = 8,
    parameter int N_cell   = 9,
    parameter int MAX_W    = 32,
    parameter int DIM_BIT  = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DIM_BIT-1:0]         cfg_width,
    input  logic [DIM_BIT-1:0]         cfg_height,
`ifdef WG_STRIDE2_EN
    input  logic                       cfg_stride2,
`endif
    input  logic [cell_bit-1:0]        pix_in,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic                       hold,
    output logic [cell_bit*N_cell-1:0] win_out,
    output logic                       win_en,
    output logic                       frame_done,
    output logic                       cfg_err,
    output wg_state_t                  fsm_state
);

    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    wg_state_t            state;
    logic [DIM_BIT-1:0]   col;
    logic [DIM_BIT-1:0]   row;
    logic [DIM_BIT-1:0]   w_reg;
    logic [DIM_BIT-1:0]   h_reg;

    // The two older columns of the current window.
    // The third, newest column comes straight from the line buffers and pix_in.
    logic [cell_bit-1:0]  sr      [0:1][0:WG_K-1];
    logic [cell_bit-1:0]  new_col [0:WG_K-1];
    logic [cell_bit-1:0]  lb0_rd;
    logic [cell_bit-1:0]  lb1_rd;

    logic                 accept;
    logic                 cfg_ok;
    logic                 col_last;
    logic                 row_last;
    logic                 in_window;
    logic [cell_bit*N_cell-1:0] win_next;

    assign pix_ready = (state == WG_RUN) && !hold;
    assign accept    = pix_valid && pix_ready;
    assign fsm_state = state;

    assign cfg_ok = (cfg_width >= DIM_BIT'(3)) && (cfg_width <= DIM_BIT'(MAX_W)) &&
                    (cfg_height >= DIM_BIT'(3));

    assign col_last = (col == w_reg - DIM_BIT'(1));
    assign row_last = (row == h_reg - DIM_BIT'(1));

`ifdef WG_STRIDE2_EN
    logic stride2;

    // (row-2) and (col-2) are even exactly when row and col are even.
    assign in_window = (row >= DIM_BIT'(2)) && (col >= DIM_BIT'(2)) &&
                       (!stride2 || (!row[0] && !col[0]));
`else
    // Windows that would straddle a row wrap are suppressed by the column gate.
    assign in_window = (row >= DIM_BIT'(2)) && (col >= DIM_BIT'(2));
`endif

    // Line buffer chain: the pixel leaving lb0 moves into lb1 at the same column.
    wg_line_buffer #(.DEPTH(MAX_W), .WIDTH(cell_bit), .AW(AW)) lb0 (
        .clk     (clk),
        .we      (accept),
        .addr    (col[AW-1:0]),
        .wr_data (pix_in),
        .rd_data (lb0_rd)
    );

    wg_line_buffer #(.DEPTH(MAX_W), .WIDTH(cell_bit), .AW(AW)) lb1 (
        .clk     (clk),
        .we      (accept),
        .addr    (col[AW-1:0]),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    assign new_col[0] = lb1_rd;
    assign new_col[1] = lb0_rd;
    assign new_col[2] = pix_in;

    always_comb begin
        win_next = '0;
        for (int r = 0; r < WG_K; r++) begin
            for (int c = 0; c < 2; c++) begin
                win_next[cell_bit*cell_idx(r, c) +: cell_bit] = sr[c][r];
            end
            win_next[cell_bit*cell_idx(r, 2) +: cell_bit] = new_col[r];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= WG_IDLE;
            col        <= '0;
            row        <= '0;
            w_reg      <= '0;
            h_reg      <= '0;
            win_out    <= '0;
            win_en     <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
`ifdef WG_STRIDE2_EN
            stride2    <= 1'b0;
`endif
            for (int r = 0; r < WG_K; r++) begin
                sr[0][r] <= '0;
                sr[1][r] <= '0;
            end
        end else begin
            win_en     <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                WG_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            w_reg <= cfg_width;
                            h_reg <= cfg_height;
                            col   <= '0;
                            row   <= '0;
`ifdef WG_STRIDE2_EN
                            stride2 <= cfg_stride2;
`endif
                            state <= WG_RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                WG_RUN: begin
                    if (accept) begin
                        for (int r = 0; r < WG_K; r++) begin
                            sr[0][r] <= sr[1][r];
                            sr[1][r] <= new_col[r];
                        end
                        if (in_window) begin
                            win_en  <= 1'b1;
                            win_out <= win_next;
                        end
                        if (col_last) begin
                            col <= '0;
                            row <= row + DIM_BIT'(1);
                        end else begin
                            col <= col + DIM_BIT'(1);
                        end
                        if (col_last && row_last) begin
                            frame_done <= 1'b1;
                            state      <= WG_IDLE;
                        end
                    end
                end
                default: state <= WG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3.
// The reference model derives each pixel's (row, col) from its raster index and the frame size.
// It builds the expected window straight from the stored frame image.
module tb_window_gen_3x3;
    import wg_pkg::*;

    localparam int CB    = 8;
    localparam int MAXW  = 32;
    localparam int DB    = 6;
    localparam int DW    = CB * 9;
    localparam int EW    = DW + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DB-1:0]     cfg_width;
    logic [DB-1:0]     cfg_height;
`ifdef WG_STRIDE2_EN
    logic              cfg_stride2;
`endif
    logic [CB-1:0]     pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic              hold;
    logic [DW-1:0]     win_out;
    logic              win_en;
    logic              frame_done;
    logic              cfg_err;
    wg_state_t         fsm_state;

    int n_checks = 0;
    int n_err    = 0;
    int win_cnt  = 0;
    int fd_cnt   = 0;
    logic acc_now = 1'b0;
    logic acc_q   = 1'b0;
    logic [EW-1:0] exp_q[$];
    logic [CB-1:0] fr [0:1023];

    window_gen_3x3 #(.cell_bit(CB), .N_cell(9), .MAX_W(MAXW), .DIM_BIT(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
`ifdef WG_STRIDE2_EN
        .cfg_stride2(cfg_stride2),
`endif
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .hold       (hold),
        .win_out    (win_out),
        .win_en     (win_en),
        .frame_done (frame_done),
        .cfg_err    (cfg_err),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Remembers whether a pixel transferred at the last rising edge.
    always @(posedge clk) acc_q <= acc_now;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model_out(input int k, input int w, input int h, input bit s2);
        int row;
        int col;
        logic en;
        logic fd;
        logic [DW-1:0] d;
        row = k / w;
        col = k % w;
        d   = '0;
        en  = (row >= 2) && (col >= 2);
        if (s2 && (((row - 2) % 2) != 0 || ((col - 2) % 2) != 0)) en = 1'b0;
        fd  = (k == w * h - 1);
        if (en) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    d[CB*(r*3+c) +: CB] = fr[(row - 2 + r) * w + (col - 2 + c)];
        end
        return {en, fd, d};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (win_en) win_cnt++;
        if (frame_done) fd_cnt++;
        if (acc_q) begin
            if (exp_q.size() == 0) begin
                check("exp_q_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("win_en", win_en, e[EW-1]);
                check("frame_done", frame_done, e[EW-2]);
                if (e[EW-1]) check("win_out", win_out, e[DW-1:0]);
            end
        end else begin
            check("no_acc_win_en", win_en, 0);
            check("no_acc_frame_done", frame_done, 0);
        end
    end

    // ---------------- driver tasks ----------------
    // gap_mode: 0 = valid every cycle, 1 = valid on alternate cycles, 2 = random gaps.
    task automatic run_frame(input int w, input int h, input int base, input bit rnd,
                             input int gap_mode, input int hold_pct, input int hold_at,
                             input int abort_at, input int start_at, input bit s2);
        int n;
        int k;
        int cyc;
        int hold_cnt;
        int budget;
        int exp_win;
        bit v;
        bit hd;
        bit aborted;
        n        = w * h;
        k        = 0;
        cyc      = 0;
        hold_cnt = 0;
        budget   = n * 10 + 40;
        aborted  = 0;
        for (int i = 0; i < n; i++) fr[i] = rnd ? CB'($urandom_range(0, 255)) : CB'(base + i);
        @(negedge clk);
        win_cnt    = 0;
        fd_cnt     = 0;
        cfg_width  = DB'(w);
        cfg_height = DB'(h);
`ifdef WG_STRIDE2_EN
        cfg_stride2 = s2;
`endif
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("state_run_after_start", fsm_state, WG_RUN);
        check("ready_after_start", pix_ready, 1);
        while (k < n && cyc < budget) begin
            v  = (gap_mode == 1) ? (cyc % 2 == 0) :
                 (gap_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            hd = (hold_cnt > 0) || (hold_pct > 0 && $urandom_range(0, 99) < hold_pct);
            if (hold_cnt > 0) hold_cnt--;
            pix_valid = v;
            hold      = hd;
            pix_in    = fr[k];
            start     = (k == start_at);
            if (k == start_at) cfg_width = DB'(2);
            #1;
            if (hd) check("hold_forces_ready_low", pix_ready, 0);
            check("cfg_err_quiet_in_run", cfg_err, 0);
            acc_now = v && pix_ready;
            if (acc_now) begin
                exp_q.push_back(model_out(k, w, h, s2));
                if (k == hold_at) hold_cnt = 3;
                if (k == abort_at) aborted = 1;
                k++;
            end
            @(negedge clk);
            cyc++;
            if (aborted) break;
        end
        pix_valid = 1'b0;
        hold      = 1'b0;
        start     = 1'b0;
        acc_now   = 1'b0;
        if (aborted) begin
            reset = 1'b0;
            @(negedge clk);
            check("abort_win_en", win_en, 0);
            check("abort_win_out", win_out, 0);
            check("abort_frame_done", frame_done, 0);
            check("abort_cfg_err", cfg_err, 0);
            check("abort_pix_ready", pix_ready, 0);
            check("abort_state", fsm_state, WG_IDLE);
            check("abort_exp_q_empty", exp_q.size(), 0);
            reset = 1'b1;
            return;
        end
        check("frame_timeout", k, n);
        // Offer a pixel after the frame; it must not be taken.
        pix_valid = 1'b1;
        @(negedge clk);
        #1;
        check("idle_ready_low", pix_ready, 0);
        @(negedge clk);
        pix_valid = 1'b0;
        exp_win = s2 ? ((w - 1) / 2) * ((h - 1) / 2) : (w - 2) * (h - 2);
        check("win_count", win_cnt, exp_win);
        check("frame_done_count", fd_cnt, 1);
        check("state_idle_after_frame", fsm_state, WG_IDLE);
        check("exp_q_empty", exp_q.size(), 0);
    endtask

    task automatic bad_cfg(input int w, input int h);
        @(negedge clk);
        cfg_width  = DB'(w);
        cfg_height = DB'(h);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_state_idle", fsm_state, WG_IDLE);
        check("cfg_err_ready_low", pix_ready, 0);
        @(negedge clk);
        check("cfg_err_one_cycle", cfg_err, 0);
        check("cfg_err_no_window", win_en, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int h;
        reset      = 1'b0;
        start      = 1'b0;
        cfg_width  = '0;
        cfg_height = '0;
`ifdef WG_STRIDE2_EN
        cfg_stride2 = 1'b0;
`endif
        pix_in     = '0;
        pix_valid  = 1'b0;
        hold       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_win_en", win_en, 0);
        check("rst_win_out", win_out, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_state", fsm_state, WG_IDLE);
        reset = 1'b1;

        // Plain 4x4 frame.
        run_frame(4, 4, 0, 0, 0, 0, -1, -1, -1, 0);
        // Same frame with a 3-cycle stall after pixel 6.
        run_frame(4, 4, 0, 0, 0, 0, 6, -1, -1, 0);
        // Rejected configurations, then a full-width 3-row frame.
        bad_cfg(2, 4);
        bad_cfg(MAXW + 1, 4);
        bad_cfg(4, 2);
        run_frame(MAXW, 3, 0, 0, 0, 0, -1, -1, -1, 0);
        // Reset in mid-frame after pixel 9, then a fresh frame.
        run_frame(4, 4, 0, 0, 0, 0, -1, 9, -1, 0);
        run_frame(4, 4, 100, 0, 0, 0, -1, -1, -1, 0);
`ifdef WG_STRIDE2_EN
        run_frame(6, 6, 0, 0, 0, 0, -1, -1, -1, 1);
        run_frame(7, 5, 0, 1, 2, 20, -1, -1, -1, 1);
`endif
        // Alternating pix_valid.
        run_frame(5, 3, 0, 1, 1, 0, -1, -1, -1, 0);
        // Random frames with gaps, stalls and an ignored start.
        repeat (6) begin
            w = $urandom_range(3, 10);
            h = $urandom_range(3, 6);
            run_frame(w, h, 0, 1, 2, 25, -1, -1, $urandom_range(1, w * h - 1), 0);
        end
        run_frame(MAXW, 4, 0, 1, 2, 10, -1, -1, -1, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
